// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: pipeline and CP0 signals seen by the exception controller
interface exc_ctrl_if #(
  parameter int EXC_TYPE_W = 4
);
  logic                  stall;
  logic                  mem_valid;
  logic [31:0]           mem_pc;
  logic                  mem_delayslot;
  logic                  mem_exc_if;
  logic                  mem_exc_ri;
  logic                  mem_exc_ov;
  logic                  mem_exc_bp;
  logic                  mem_exc_sys;
  logic                  mem_exc_adel;
  logic                  mem_exc_ades;
  logic                  mem_eret;
  logic [31:0]           mem_badvaddr;
  logic                  cp0_write_en;
  logic [4:0]            cp0_write_addr;
  logic [31:0]           cp0_write_data;
  logic [31:0]           cp0_status;
  logic [31:0]           cp0_cause;
  logic [31:0]           cp0_epc;
  logic [5:0]            interrupt_i;
  logic [5:0]            interrupt_o;
  logic [EXC_TYPE_W-1:0] exception_type;
  logic                  delayslot_flag;
  logic [31:0]           current_pc_addr;
  logic [31:0]           cp0_badvaddr_write_data;
  logic                  flush;
  logic [31:0]           exc_pc;
  modport master (
    output stall, mem_valid, mem_pc, mem_delayslot, mem_exc_if, mem_exc_ri, mem_exc_ov,
           mem_exc_bp, mem_exc_sys, mem_exc_adel, mem_exc_ades, mem_eret, mem_badvaddr,
           cp0_write_en, cp0_write_addr, cp0_write_data, cp0_status, cp0_cause, cp0_epc,
           interrupt_i,
    input  interrupt_o, exception_type, delayslot_flag, current_pc_addr,
           cp0_badvaddr_write_data, flush, exc_pc
  );
  modport slave (
    input  stall, mem_valid, mem_pc, mem_delayslot, mem_exc_if, mem_exc_ri, mem_exc_ov,
           mem_exc_bp, mem_exc_sys, mem_exc_adel, mem_exc_ades, mem_eret, mem_badvaddr,
           cp0_write_en, cp0_write_addr, cp0_write_data, cp0_status, cp0_cause, cp0_epc,
           interrupt_i,
    output interrupt_o, exception_type, delayslot_flag, current_pc_addr,
           cp0_badvaddr_write_data, flush, exc_pc
  );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: commit-point exception arbitration, flush/redirect and wrong-path squash
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
  parameter int          SQUASH_CYCLES = 3,
  parameter int          EXC_TYPE_W    = 4
) (
  input logic       clk,
  input logic       rst,
  exc_ctrl_if.slave bus
);
  localparam logic [EXC_TYPE_W-1:0] C_NONE = EXC_TYPE_W'(0);
  localparam logic [EXC_TYPE_W-1:0] C_INT  = EXC_TYPE_W'(1);
  localparam logic [EXC_TYPE_W-1:0] C_IF   = EXC_TYPE_W'(2);
  localparam logic [EXC_TYPE_W-1:0] C_RI   = EXC_TYPE_W'(3);
  localparam logic [EXC_TYPE_W-1:0] C_OV   = EXC_TYPE_W'(4);
  localparam logic [EXC_TYPE_W-1:0] C_BP   = EXC_TYPE_W'(5);
  localparam logic [EXC_TYPE_W-1:0] C_SYS  = EXC_TYPE_W'(6);
  localparam logic [EXC_TYPE_W-1:0] C_ADEL = EXC_TYPE_W'(7);
  localparam logic [EXC_TYPE_W-1:0] C_ADES = EXC_TYPE_W'(8);
  localparam logic [EXC_TYPE_W-1:0] C_ERET = EXC_TYPE_W'(9);
  typedef enum logic {IDLE, SQUASH} state_t;
  state_t                state_q;
  logic [2:0]            cnt_q;
  logic [5:0]            sync1_q, sync2_q;
  logic [15:0]           eff_status;
  logic [31:0]           eff_epc;
  logic [1:0]            eff_sw;
  logic                  int_req, commit, flush_d;
  logic [EXC_TYPE_W-1:0] type_d;
  // two-flop synchroniser for the raw hardware interrupt lines
  always_ff @(posedge clk or negedge rst)
    if (!rst) {sync2_q, sync1_q} <= '0;
    else {sync2_q, sync1_q} <= {sync1_q, bus.interrupt_i};
  // CP0 view with an in-flight MTC0 forwarded, then priority arbitration
  always_comb begin
    eff_status = (bus.cp0_write_en && bus.cp0_write_addr == 5'd12) ? bus.cp0_write_data[15:0] : bus.cp0_status[15:0];
    eff_sw     = (bus.cp0_write_en && bus.cp0_write_addr == 5'd13) ? bus.cp0_write_data[9:8] : bus.cp0_cause[9:8];
    eff_epc    = (bus.cp0_write_en && bus.cp0_write_addr == 5'd14) ? bus.cp0_write_data : bus.cp0_epc;
    int_req    = eff_status[0] && !eff_status[1] && |({sync2_q, eff_sw} & eff_status[15:8]);
    commit     = rst && bus.mem_valid && !bus.stall && state_q == IDLE;
    type_d     = !commit          ? C_NONE :
                 int_req          ? C_INT  :
                 bus.mem_exc_if   ? C_IF   :
                 bus.mem_exc_ri   ? C_RI   :
                 bus.mem_exc_ov   ? C_OV   :
                 bus.mem_exc_bp   ? C_BP   :
                 bus.mem_exc_sys  ? C_SYS  :
                 bus.mem_exc_adel ? C_ADEL :
                 bus.mem_exc_ades ? C_ADES :
                 bus.mem_eret     ? C_ERET : C_NONE;
    flush_d    = type_d != C_NONE;
  end
  assign bus.interrupt_o             = sync2_q;
  assign bus.exception_type          = type_d;
  assign bus.flush                   = flush_d;
  assign bus.delayslot_flag          = rst && bus.mem_delayslot;
  assign bus.current_pc_addr         = rst ? bus.mem_pc : 32'd0;
  assign bus.cp0_badvaddr_write_data = type_d == C_IF ? bus.mem_pc :
                                       (type_d == C_ADEL || type_d == C_ADES) ? bus.mem_badvaddr : 32'd0;
  assign bus.exc_pc                  = !flush_d ? 32'd0 : type_d == C_ERET ? eff_epc : EXC_VECTOR;
  // squash window: hold off new exceptions for SQUASH_CYCLES cycles after a flush
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (state_q == IDLE) begin
      if (flush_d) begin
        state_q <= SQUASH;
        cnt_q   <= 3'(SQUASH_CYCLES - 1);
      end
    end else if (cnt_q == 3'd0) state_q <= IDLE;
    else cnt_q <= cnt_q - 3'd1;
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed plan plus random traffic against a spec-level model
module tb_exc_ctrl;
  localparam int SQ = 3;
  logic clk = 0;
  logic rst = 0;
  int vecs = 0;
  int errs = 0;
  int sq_left = 0;
  int last_et = 0;
  logic [5:0] q[$];
  exc_ctrl_if bus ();
  exc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.stall = 0; bus.mem_valid = 0; bus.mem_pc = 0; bus.mem_delayslot = 0;
    bus.mem_exc_if = 0; bus.mem_exc_ri = 0; bus.mem_exc_ov = 0; bus.mem_exc_bp = 0;
    bus.mem_exc_sys = 0; bus.mem_exc_adel = 0; bus.mem_exc_ades = 0; bus.mem_eret = 0;
    bus.mem_badvaddr = 0; bus.cp0_write_en = 0; bus.cp0_write_addr = 0; bus.cp0_write_data = 0;
    bus.cp0_status = 0; bus.cp0_cause = 0; bus.cp0_epc = 0; bus.interrupt_i = 0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] st, ca, ep, bv, xp;
    logic [8:0] fl;
    int et;
    if (!rst) begin
      q = '{6'd0, 6'd0};
      sq_left = 0;
    end
    st = (bus.cp0_write_en && bus.cp0_write_addr == 5'd12) ? bus.cp0_write_data : bus.cp0_status;
    ca = (bus.cp0_write_en && bus.cp0_write_addr == 5'd13) ? bus.cp0_write_data : bus.cp0_cause;
    ep = (bus.cp0_write_en && bus.cp0_write_addr == 5'd14) ? bus.cp0_write_data : bus.cp0_epc;
    fl[0] = st[0] && !st[1] && ((({q[0], ca[9:8]}) & st[15:8]) != 8'd0);
    fl[1] = bus.mem_exc_if;   fl[2] = bus.mem_exc_ri;   fl[3] = bus.mem_exc_ov;
    fl[4] = bus.mem_exc_bp;   fl[5] = bus.mem_exc_sys;  fl[6] = bus.mem_exc_adel;
    fl[7] = bus.mem_exc_ades; fl[8] = bus.mem_eret;
    et = 0;
    if (rst && bus.mem_valid && !bus.stall && sq_left == 0)
      for (int k = 8; k >= 0; k--) if (fl[k]) et = k + 1;
    last_et = et;
    bv = et == 2 ? bus.mem_pc : (et == 7 || et == 8) ? bus.mem_badvaddr : 32'd0;
    xp = et == 0 ? 32'd0 : et == 9 ? ep : 32'hBFC00380;
    chk({tag, "/type"}, 32'(bus.exception_type), 32'(et));
    chk({tag, "/flush"}, 32'(bus.flush), 32'(et != 0));
    chk({tag, "/exc_pc"}, bus.exc_pc, xp);
    chk({tag, "/badvaddr"}, bus.cp0_badvaddr_write_data, bv);
    chk({tag, "/cur_pc"}, bus.current_pc_addr, rst ? bus.mem_pc : 32'd0);
    chk({tag, "/dslot"}, 32'(bus.delayslot_flag), 32'(rst && bus.mem_delayslot));
    chk({tag, "/int_o"}, 32'(bus.interrupt_o), 32'(q[0]));
  endtask

  task automatic settle(input string tag);
    #3;
    check_all(tag);
  endtask

  task automatic tick();
    logic [5:0] ii;
    ii = bus.interrupt_i;
    @(posedge clk);
    if (rst) begin
      void'(q.pop_front());
      q.push_back(ii);
      if (sq_left > 0) sq_left--;
      else if (last_et != 0) sq_left = SQ;
    end
    #1;
  endtask

  task automatic cyc(input string tag);
    settle(tag);
    tick();
  endtask

  task automatic idle(input int n);
    clear_in();
    for (int i = 0; i < n; i++) cyc("idle");
  endtask

  initial begin
    q = '{6'd0, 6'd0};
    clear_in();
    #1;
    check_all("reset");
    chk("reset/type0", 32'(bus.exception_type), 32'd0);
    tick();
    rst = 1;
    idle(2);
    // priority RI over OV, then exactly SQ suppressed cycles
    bus.mem_valid = 1; bus.mem_exc_ri = 1; bus.mem_exc_ov = 1; bus.mem_pc = 32'hBFC00100;
    settle("prio");
    chk("prio/code", 32'(bus.exception_type), 32'd3);
    chk("prio/vec", bus.exc_pc, 32'hBFC00380);
    chk("prio/pc", bus.current_pc_addr, 32'hBFC00100);
    tick();
    for (int i = 0; i < SQ; i++) begin
      settle("squash");
      chk("squash/code", 32'(bus.exception_type), 32'd0);
      tick();
    end
    settle("prio2");
    chk("prio2/code", 32'(bus.exception_type), 32'd3);
    tick();
    idle(4);
    // interrupt through the synchroniser
    bus.cp0_status = 32'h0000FF01; bus.interrupt_i = 6'b000100; bus.mem_valid = 1;
    for (int i = 0; i < 2; i++) begin
      settle("int_wait");
      chk("int_wait/code", 32'(bus.exception_type), 32'd0);
      tick();
    end
    settle("int");
    chk("int/code", 32'(bus.exception_type), 32'd1);
    tick();
    bus.mem_valid = 0;
    for (int i = 0; i < 4; i++) cyc("int_novalid");
    bus.cp0_write_en = 1; bus.cp0_write_addr = 5'd12; bus.cp0_write_data = 32'h0000FF00; bus.mem_valid = 1;
    settle("int_mtc0");
    chk("int_mtc0/code", 32'(bus.exception_type), 32'd0);
    tick();
    bus.cp0_write_en = 0;
    settle("int_late");
    chk("int_late/code", 32'(bus.exception_type), 32'd1);
    tick();
    for (int i = 0; i < SQ; i++) cyc("int_sq");
    bus.cp0_status = 32'h0000FF03;
    for (int i = 0; i < 4; i++) begin
      settle("exl");
      chk("exl/code", 32'(bus.exception_type), 32'd0);
      tick();
    end
    idle(4);
    // address errors
    bus.mem_valid = 1; bus.mem_exc_adel = 1; bus.mem_badvaddr = 32'h80000003;
    settle("adel");
    chk("adel/code", 32'(bus.exception_type), 32'd7);
    chk("adel/bv", bus.cp0_badvaddr_write_data, 32'h80000003);
    tick();
    idle(4);
    bus.mem_valid = 1; bus.mem_exc_if = 1; bus.mem_pc = 32'h80000002;
    settle("if");
    chk("if/code", 32'(bus.exception_type), 32'd2);
    chk("if/bv", bus.cp0_badvaddr_write_data, 32'h80000002);
    tick();
    idle(4);
    // ERET with EPC bypass
    bus.mem_valid = 1; bus.mem_eret = 1; bus.cp0_epc = 32'h1000;
    bus.cp0_write_en = 1; bus.cp0_write_addr = 5'd14; bus.cp0_write_data = 32'h2000;
    settle("eret");
    chk("eret/code", 32'(bus.exception_type), 32'd9);
    chk("eret/pc", bus.exc_pc, 32'h2000);
    tick();
    idle(4);
    // stall hold
    bus.mem_valid = 1; bus.mem_exc_sys = 1; bus.stall = 1; bus.mem_delayslot = 1;
    for (int i = 0; i < 4; i++) begin
      settle("stall");
      chk("stall/flush", 32'(bus.flush), 32'd0);
      tick();
    end
    bus.stall = 0;
    settle("unstall");
    chk("unstall/flush", 32'(bus.flush), 32'd1);
    chk("unstall/code", 32'(bus.exception_type), 32'd6);
    chk("unstall/ds", 32'(bus.delayslot_flag), 32'd1);
    tick();
    idle(4);
    // reset in the middle of the squash window
    bus.mem_valid = 1; bus.mem_exc_ri = 1; bus.mem_pc = 32'h40;
    cyc("rst_flush");
    settle("rst_sq");
    #1 rst = 0;
    #1;
    check_all("rst_mid");
    chk("rst_mid/flush", 32'(bus.flush), 32'd0);
    chk("rst_mid/pc", bus.current_pc_addr, 32'd0);
    tick();
    rst = 1;
    settle("rst_after");
    chk("rst_after/code", 32'(bus.exception_type), 32'd3);
    tick();
    idle(4);
    // random traffic
    for (int n = 0; n < 500; n++) begin
      bus.stall = ($urandom_range(4) == 0);
      bus.mem_valid = ($urandom_range(3) != 0);
      bus.mem_pc = $urandom; bus.mem_delayslot = $urandom_range(1);
      bus.mem_exc_if = ($urandom_range(11) == 0); bus.mem_exc_ri = ($urandom_range(11) == 0);
      bus.mem_exc_ov = ($urandom_range(11) == 0); bus.mem_exc_bp = ($urandom_range(11) == 0);
      bus.mem_exc_sys = ($urandom_range(11) == 0); bus.mem_exc_adel = ($urandom_range(11) == 0);
      bus.mem_exc_ades = ($urandom_range(11) == 0); bus.mem_eret = ($urandom_range(11) == 0);
      bus.mem_badvaddr = $urandom;
      bus.cp0_write_en = ($urandom_range(4) == 0);
      bus.cp0_write_addr = 5'($urandom_range(11, 15));
      bus.cp0_write_data = $urandom;
      case ($urandom_range(3))
        0: bus.cp0_status = 32'h0000FF01;
        1: bus.cp0_status = 32'h0000FF03;
        2: bus.cp0_status = 32'h00000000;
        default: bus.cp0_status = $urandom;
      endcase
      bus.cp0_cause = $urandom; bus.cp0_epc = $urandom;
      if ($urandom_range(7) == 0) bus.interrupt_i = 6'($urandom);
      rst = ($urandom_range(149) != 0);
      cyc("rand");
    end
    rst = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
